// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core: operator codes, FSM states,
// operand width and the decimal-append helper used during key entry.
package calc_pkg;

  localparam int BIN_W = 14;
  localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;
  localparam logic [15:0] ERR_CODE_DEF = 16'hEEEE;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_OP_SET,
    ST_ENTER_B,
    ST_EXEC,
    ST_DIVIDE,
    ST_CONVERT,
    ST_RESULT,
    ST_ERROR
  } state_e;

  // v*10 + d; callers guarantee v <= 999 so the result stays within BIN_W bits
  function automatic logic [BIN_W-1:0] dec_append(input logic [BIN_W-1:0] v,
                                                  input logic [3:0] d);
    return (v << 3) + (v << 1) + {{(BIN_W-4){1'b0}}, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: a start pulse loads the binary input,
// BIN_W shift cycles later done_o pulses for one cycle with bcd_o valid.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_w;
  logic [BCD_W-1:0] shf_w;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_w[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign shf_w = BCD_W'({adj_w, bin_q[BIN_W-1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q <= bin_i;
        bcd_q <= '0;
        cnt_q <= CNT_W'(BIN_W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        bin_q <= bin_q << 1;
        bcd_q <= shf_w;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_core.sv
// Four-function decimal calculator: key-event FSM, inline restoring divider,
// and a sequential BCD converter feeding the single registered display word.
module calc_core
  import calc_pkg::*;
#(
  parameter int          DIGITS   = 4,
  parameter logic [15:0] ERR_CODE = ERR_CODE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_num,
  input  logic                is_op,
  input  logic                is_eq,
  input  logic [3:0]          num_val,
  input  logic [1:0]          op_val,
  output logic [4*DIGITS-1:0] data_out_bcd,
  output logic                busy,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int DIV_W = $clog2(BIN_W);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [BIN_W-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [DIV_W-1:0] dcnt_q, dcnt_d;
  op_e              op_q, op_d, pend_op_q, pend_op_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] ent_q, ent_d, disp_q, disp_d;
  logic             num_prev_q, op_prev_q, eq_prev_q;

  logic             busy_w, eq_ev, op_ev, num_ev, room_w;
  logic [BIN_W:0]   sum_w;
  logic [BIN_W-1:0] diff_w;
  logic [2*BIN_W-1:0] prod_w;
  logic [BIN_W:0]   trial_w;
  logic             fits_w;
  logic [BIN_W-1:0] rem_n_w, quo_n_w;
  logic [BCD_W-1:0] ent_app_w, ent_new_w;
  logic             conv_start, conv_done;
  logic [BIN_W-1:0] conv_bin;
  logic [BCD_W-1:0] conv_bcd;

  assign busy_w = (state_q == ST_EXEC) || (state_q == ST_DIVIDE) || (state_q == ST_CONVERT);

  // Coinciding edges resolve eq > op > num; out-of-range digits are not events
  assign eq_ev  = is_eq  & ~eq_prev_q  & ~busy_w;
  assign op_ev  = is_op  & ~op_prev_q  & ~busy_w & ~eq_ev;
  assign num_ev = is_num & ~num_prev_q & ~busy_w & ~eq_ev & ~op_ev & (num_val <= 4'd9);

  assign room_w    = cnt_q < CNT_W'(DIGITS);
  assign ent_app_w = {ent_q[BCD_W-5:0], num_val};
  assign ent_new_w = {{(BCD_W-4){1'b0}}, num_val};

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = a_q - b_q;
  assign prod_w = {{BIN_W{1'b0}}, a_q} * {{BIN_W{1'b0}}, b_q};

  assign trial_w = {rem_q, quo_q[BIN_W-1]};
  assign fits_w  = trial_w >= {1'b0, b_q};
  assign rem_n_w = fits_w ? (trial_w[BIN_W-1:0] - b_q) : trial_w[BIN_W-1:0];
  assign quo_n_w = {quo_q[BIN_W-2:0], fits_w};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dcnt_d     = dcnt_q;
    op_d       = op_q;
    pend_op_d  = pend_op_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    ent_d      = ent_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    conv_bin   = res_q;

    case (state_q)
      ST_ENTER_A: begin
        if (op_ev) begin
          op_d    = op_e'(op_val);
          state_d = ST_OP_SET;
        end else if (num_ev && room_w) begin
          a_d    = dec_append(a_q, num_val);
          ent_d  = ent_app_w;
          disp_d = ent_app_w;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_OP_SET: begin
        if (op_ev) begin
          op_d = op_e'(op_val);
        end else if (num_ev) begin
          b_d     = {{(BIN_W-4){1'b0}}, num_val};
          ent_d   = ent_new_w;
          disp_d  = ent_new_w;
          cnt_d   = CNT_W'(1);
          state_d = ST_ENTER_B;
        end
      end
      ST_ENTER_B: begin
        if (eq_ev) begin
          pend_vld_d = 1'b0;
          state_d    = ST_EXEC;
        end else if (op_ev) begin
          pend_vld_d = 1'b1;
          pend_op_d  = op_e'(op_val);
          state_d    = ST_EXEC;
        end else if (num_ev && room_w) begin
          b_d    = dec_append(b_q, num_val);
          ent_d  = ent_app_w;
          disp_d = ent_app_w;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        state_d = ST_ERROR;
        case (op_q)
          OP_ADD: if (sum_w <= {1'b0, MAX_VAL}) begin
            res_d    = sum_w[BIN_W-1:0];
            state_d  = ST_CONVERT;
          end
          OP_SUB: if (b_q <= a_q) begin
            res_d    = diff_w;
            state_d  = ST_CONVERT;
          end
          OP_MUL: if (prod_w <= {{BIN_W{1'b0}}, MAX_VAL}) begin
            res_d    = prod_w[BIN_W-1:0];
            state_d  = ST_CONVERT;
          end
          default: if (b_q != '0) begin
            rem_d    = '0;
            quo_d    = a_q;
            dcnt_d   = DIV_W'(BIN_W - 1);
            state_d  = ST_DIVIDE;
          end
        endcase
        if (state_d == ST_CONVERT) begin
          conv_start = 1'b1;
          conv_bin   = res_d;
        end
        if (state_d == ST_ERROR) begin
          disp_d     = ERR_CODE;
          pend_vld_d = 1'b0;
        end
      end
      ST_DIVIDE: begin
        rem_d  = rem_n_w;
        quo_d  = quo_n_w;
        dcnt_d = dcnt_q - DIV_W'(1);
        if (dcnt_q == '0) begin
          res_d      = quo_n_w;
          conv_start = 1'b1;
          conv_bin   = quo_n_w;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          disp_d = conv_bcd;
          if (pend_vld_q) begin
            a_d        = res_q;
            op_d       = pend_op_q;
            pend_vld_d = 1'b0;
            state_d    = ST_OP_SET;
          end else begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_RESULT: begin
        if (op_ev) begin
          a_d     = res_q;
          op_d    = op_e'(op_val);
          state_d = ST_OP_SET;
        end else if (num_ev) begin
          a_d     = {{(BIN_W-4){1'b0}}, num_val};
          ent_d   = ent_new_w;
          disp_d  = ent_new_w;
          cnt_d   = CNT_W'(1);
          state_d = ST_ENTER_A;
        end
      end
      ST_ERROR: begin
        if (num_ev) begin
          a_d     = {{(BIN_W-4){1'b0}}, num_val};
          b_d     = '0;
          op_d    = OP_ADD;
          ent_d   = ent_new_w;
          disp_d  = ent_new_w;
          cnt_d   = CNT_W'(1);
          state_d = ST_ENTER_A;
        end
      end
      default: state_d = ST_ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dcnt_q     <= '0;
      op_q       <= OP_ADD;
      pend_op_q  <= OP_ADD;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      ent_q      <= '0;
      disp_q     <= '0;
      num_prev_q <= 1'b0;
      op_prev_q  <= 1'b0;
      eq_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dcnt_q     <= dcnt_d;
      op_q       <= op_d;
      pend_op_q  <= pend_op_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      ent_q      <= ent_d;
      disp_q     <= disp_d;
      num_prev_q <= is_num;
      op_prev_q  <= is_op;
      eq_prev_q  <= is_eq;
    end
  end

  bin2bcd_seq #(
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign data_out_bcd = disp_q;
  assign busy         = busy_w;
  assign err          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_calc_core.sv
// Directed key-sequence bench for calc_core with hand-computed display values.
module tb_calc_core;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_num = 1'b0;
  logic        is_op = 1'b0;
  logic        is_eq = 1'b0;
  logic [3:0]  num_val = 4'd0;
  logic [1:0]  op_val = 2'd0;
  logic [15:0] data_out_bcd;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_seen;

  always #5 clk = ~clk;

  calc_core #(
    .DIGITS   (4),
    .ERR_CODE (16'hEEEE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .is_num       (is_num),
    .is_op        (is_op),
    .is_eq        (is_eq),
    .num_val      (num_val),
    .op_val       (op_val),
    .data_out_bcd (data_out_bcd),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic key_num(input logic [3:0] d);
    @(negedge clk);
    num_val = d;
    is_num  = 1'b1;
    @(negedge clk);
    is_num = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic key_op(input logic [1:0] o);
    @(negedge clk);
    op_val = o;
    is_op  = 1'b1;
    @(negedge clk);
    is_op = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raise '=' and check the display exactly at the latency bound
  task automatic eq_check(input string tag, input logic [15:0] exp, input int lim);
    busy_seen = 0;
    @(negedge clk);
    is_eq = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen = 1;
    end
    chk(tag, {16'h0, data_out_bcd}, {16'h0, exp});
    @(negedge clk);
    is_eq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_disp", {16'h0, data_out_bcd}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-entry
    key_num(4'd1);
    key_num(4'd2);
    chk("entry_12", {16'h0, data_out_bcd}, 32'h0012);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_disp", {16'h0, data_out_bcd}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-compute leaves no partial result
    key_num(4'd1); key_op(ADD); key_num(4'd2);
    @(negedge clk);
    is_eq = 1'b1;
    repeat (6) @(posedge clk);
    #2 chk("busy_before_abort", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1 chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_disp", {16'h0, data_out_bcd}, 32'h0);
    @(negedge clk);
    is_eq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_partial", {16'h0, data_out_bcd}, 32'h0);

    // 12 + 34 = 46
    do_reset();
    key_num(4'd1); key_num(4'd2);
    chk("add_a", {16'h0, data_out_bcd}, 32'h0012);
    key_op(ADD);
    chk("add_opset", {16'h0, data_out_bcd}, 32'h0012);
    key_num(4'd3); key_num(4'd4);
    chk("add_b", {16'h0, data_out_bcd}, 32'h0034);
    eq_check("add_res", 16'h0046, 18);
    chk("add_busy_pulse", busy_seen, 1);
    chk("add_err", {31'h0, err}, 32'h0);

    // fifth digit ignored, overflow on multiply, recovery by a digit
    do_reset();
    for (int i = 0; i < 5; i++) key_num(4'd9);
    chk("sat_9999", {16'h0, data_out_bcd}, 32'h9999);
    key_op(MUL);
    key_num(4'd2);
    chk("mul_b", {16'h0, data_out_bcd}, 32'h0002);
    eq_check("mul_ovf", 16'hEEEE, 3);
    chk("mul_ovf_err", {31'h0, err}, 32'h1);
    key_num(4'd5);
    chk("recover_disp", {16'h0, data_out_bcd}, 32'h0005);
    chk("recover_err", {31'h0, err}, 32'h0);

    // negative, division, divide by zero
    do_reset();
    key_num(4'd7); key_op(SUB); key_num(4'd9);
    eq_check("sub_neg", 16'hEEEE, 3);
    key_num(4'd1); key_num(4'd0); key_num(4'd0);
    chk("div_a", {16'h0, data_out_bcd}, 32'h0100);
    key_op(DIV); key_num(4'd7);
    eq_check("div_100_7", 16'h0014, 32);
    key_num(4'd5);
    chk("new_a_after_res", {16'h0, data_out_bcd}, 32'h0005);
    key_op(DIV); key_num(4'd0);
    eq_check("div_zero", 16'hEEEE, 3);
    chk("div_zero_err", {31'h0, err}, 32'h1);

    // chaining: 2 + 3 * 4 = 20, then + 1 = 21
    do_reset();
    key_num(4'd2); key_op(ADD); key_num(4'd3); key_op(MUL);
    repeat (20) @(negedge clk);
    chk("chain_mid", {16'h0, data_out_bcd}, 32'h0005);
    chk("chain_mid_busy", {31'h0, busy}, 32'h0);
    key_num(4'd4);
    eq_check("chain_res", 16'h0020, 18);
    key_op(ADD); key_num(4'd1);
    eq_check("chain_cont", 16'h0021, 18);

    // held key counts once; out-of-range digit ignored
    do_reset();
    @(negedge clk);
    num_val = 4'd7;
    is_num  = 1'b1;
    repeat (50) @(negedge clk);
    is_num = 1'b0;
    @(negedge clk);
    chk("held_key", {16'h0, data_out_bcd}, 32'h0007);
    key_num(4'd8);
    chk("after_held", {16'h0, data_out_bcd}, 32'h0078);
    key_num(4'd12);
    chk("digit_gt9", {16'h0, data_out_bcd}, 32'h0078);

    // digit edge while busy is dropped
    do_reset();
    key_num(4'd1); key_op(ADD); key_num(4'd2);
    @(negedge clk);
    is_eq = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("busy_drop_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    num_val = 4'd9;
    is_num  = 1'b1;
    @(negedge clk);
    is_num = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("busy_drop_res", {16'h0, data_out_bcd}, 32'h0003);
    @(negedge clk);
    is_eq = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_drop_hold", {16'h0, data_out_bcd}, 32'h0003);
    key_num(4'd4);
    chk("busy_drop_next", {16'h0, data_out_bcd}, 32'h0004);

    // '=' and '+' in the same cycle: '=' wins, nothing pending
    do_reset();
    key_num(4'd1); key_op(ADD); key_num(4'd2);
    @(negedge clk);
    op_val = ADD;
    is_op  = 1'b1;
    is_eq  = 1'b1;
    repeat (18) @(posedge clk);
    #1 chk("eq_wins_res", {16'h0, data_out_bcd}, 32'h0003);
    @(negedge clk);
    is_op = 1'b0;
    is_eq = 1'b0;
    repeat (2) @(negedge clk);
    key_num(4'd4);
    eq_check("eq_wins_noop", 16'h0004, 18);
    chk("eq_wins_nobusy", busy_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
